// File: rtl/can_bit_timing.sv
// CAN bit-timing controller.
// Enables the time-quantum generator, counts its quantum pulses through the
// SYNC_SEG / TSEG1 / TSEG2 segments, and marks the bit start and sample point.
// Falling RX edges (recessive to dominant) cause either a hard synchronization
// or an SJW-limited resynchronization (at most one per bit).
module can_bit_timing #(
    parameter int TSEG1 = 13,
    parameter int TSEG2 = 2,
    parameter int SJW   = 1
) (
    input  logic       clock_in_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       tq_pulse_i,
    input  logic       rx_i,
    input  logic       hard_sync_i,
    output logic       clk_gen_en_o,
    output logic       bit_start_o,
    output logic       sample_o,
    output logic       sample_bit_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TSEG1 = 2'd2,
        ST_TSEG2 = 2'd3
    } state_t;

    localparam logic [4:0] TSEG1_C = 5'(TSEG1);
    localparam logic [4:0] TSEG2_C = 5'(TSEG2);
    localparam logic [4:0] SJW_C   = 5'(SJW);

    // Phase-buffer lengthening in TSEG1 never exceeds the phase error (cnt+1).
    function automatic logic [4:0] min5(input logic [4:0] a, input logic [4:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t     state_r,     state_s;
    logic [4:0] cnt_r,       cnt_s;
    logic [4:0] lim1_r,      lim1_s;
    logic [4:0] lim2_r,      lim2_s;
    logic       edge_used_r, edge_used_s;
    logic       rx_prev_r;
    logic       bit_start_r, bit_start_s;
    logic       sample_r,    sample_s;
    logic       sample_bit_r, sample_bit_s;
    logic       clk_gen_en_r;

    logic [4:0] cnt_inc_s;
    logic [4:0] lim1_adj_s;
    logic [4:0] lim2_adj_s;
    logic [4:0] rem_s;
    logic       fall_s;
    logic       resync_s;

    // Next-state, segment counter/limit and output-pulse computation.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        lim1_s       = lim1_r;
        lim2_s       = lim2_r;
        edge_used_s  = edge_used_r;
        bit_start_s  = 1'b0;
        sample_s     = 1'b0;
        sample_bit_s = sample_bit_r;
        cnt_inc_s    = cnt_r + 5'd1;
        lim1_adj_s   = lim1_r;
        lim2_adj_s   = lim2_r;
        rem_s        = lim2_r - cnt_r;
        fall_s       = rx_prev_r & ~rx_i;
        resync_s     = fall_s & ~hard_sync_i & ~edge_used_r & sample_bit_r;

        if (!en_i) begin
            // Disabling drops whatever segment was in progress.
            state_s     = ST_IDLE;
            cnt_s       = 5'd0;
            edge_used_s = 1'b0;
        end else if (fall_s && hard_sync_i && (state_r != ST_IDLE)) begin
            // Hard sync restarts the bit; a coincident quantum pulse is consumed.
            state_s     = ST_TSEG1;
            cnt_s       = 5'd0;
            lim1_s      = TSEG1_C;
            bit_start_s = 1'b1;
            edge_used_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s     = ST_SYNC;
                    bit_start_s = 1'b1;
                    edge_used_s = 1'b0;
                end
                ST_SYNC: begin
                    if (resync_s) begin
                        edge_used_s = 1'b1;
                    end else begin
                        edge_used_s = edge_used_r;
                    end
                    if (tq_pulse_i) begin
                        state_s = ST_TSEG1;
                        cnt_s   = 5'd0;
                        lim1_s  = TSEG1_C;
                    end else begin
                        state_s = ST_SYNC;
                    end
                end
                ST_TSEG1: begin
                    if (resync_s) begin
                        lim1_adj_s  = lim1_r + min5(cnt_inc_s, SJW_C);
                        edge_used_s = 1'b1;
                    end else begin
                        lim1_adj_s  = lim1_r;
                    end
                    lim1_s = lim1_adj_s;
                    if (tq_pulse_i) begin
                        if (cnt_inc_s == lim1_adj_s) begin
                            state_s      = ST_TSEG2;
                            cnt_s        = 5'd0;
                            lim2_s       = TSEG2_C;
                            sample_s     = 1'b1;
                            sample_bit_s = rx_i;
                        end else begin
                            cnt_s = cnt_inc_s;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_TSEG2: begin
                    if (resync_s && (rem_s <= SJW_C)) begin
                        // Edge too close to the bit end: finish the bit now.
                        state_s     = ST_SYNC;
                        cnt_s       = 5'd0;
                        bit_start_s = 1'b1;
                        edge_used_s = 1'b0;
                    end else begin
                        if (resync_s) begin
                            lim2_adj_s  = lim2_r - SJW_C;
                            edge_used_s = 1'b1;
                        end else begin
                            lim2_adj_s  = lim2_r;
                        end
                        lim2_s = lim2_adj_s;
                        if (tq_pulse_i) begin
                            if (cnt_inc_s == lim2_adj_s) begin
                                state_s     = ST_SYNC;
                                cnt_s       = 5'd0;
                                bit_start_s = 1'b1;
                                edge_used_s = 1'b0;
                            end else begin
                                cnt_s = cnt_inc_s;
                            end
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 5'd0;
                end
            endcase
        end
    end

    // State, counters, edge history and registered outputs.
    always_ff @(posedge clock_in_i) begin
        if (!reset_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 5'd0;
            lim1_r       <= 5'd0;
            lim2_r       <= 5'd0;
            edge_used_r  <= 1'b0;
            rx_prev_r    <= 1'b1;
            bit_start_r  <= 1'b0;
            sample_r     <= 1'b0;
            sample_bit_r <= 1'b1;
            clk_gen_en_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            lim1_r       <= lim1_s;
            lim2_r       <= lim2_s;
            edge_used_r  <= edge_used_s;
            rx_prev_r    <= rx_i;
            bit_start_r  <= bit_start_s;
            sample_r     <= sample_s;
            sample_bit_r <= sample_bit_s;
            clk_gen_en_r <= (state_s != ST_IDLE);
        end
    end

    assign state_o      = state_r;
    assign clk_gen_en_o = clk_gen_en_r;
    assign bit_start_o  = bit_start_r;
    assign sample_o     = sample_r;
    assign sample_bit_o = sample_bit_r;

endmodule

// File: tb/tb_can_bit_timing.sv
// Self-checking bench for can_bit_timing (default TSEG1=13, TSEG2=2, SJW=1).
// A quantum pulse is driven every 4 cycles. Expected bit lengths and sample
// points (in tq counted since the last bit_start) are queued when stimulus is
// set up and checked whenever the DUT pulses bit_start_o / sample_o.
module tb_can_bit_timing;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       en_i = 1'b0;
    logic       tq_pulse_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       hard_sync_i = 1'b0;
    logic       clk_gen_en_o;
    logic       bit_start_o;
    logic       sample_o;
    logic       sample_bit_o;
    logic [1:0] state_o;

    can_bit_timing dut (
        .clock_in_i   (clk),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .tq_pulse_i   (tq_pulse_i),
        .rx_i         (rx_i),
        .hard_sync_i  (hard_sync_i),
        .clk_gen_en_o (clk_gen_en_o),
        .bit_start_o  (bit_start_o),
        .sample_o     (sample_o),
        .sample_bit_o (sample_bit_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rx;
        logic [1:0] st;
        logic       bs;
        logic       cen;
        logic       smp;
        logic       sbit;
    } vec_t;

    vec_t tbl [4];

    int n_cmp = 0;
    int n_err = 0;
    int phase = 0;
    int tq_cnt = 0;
    int bs_q[$];
    int samp_cnt_q[$];
    int samp_bit_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive the quantum pulse, sample #1 after the edge, score events.
    task automatic step();
        int e;
        tq_pulse_i = (phase == 3);
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
        if (tq_pulse_i) tq_cnt++;
        if (bit_start_o) begin
            if (bs_q.size() == 0) begin
                check("unexpected_bit_start", 32'd1, 32'd0);
            end else begin
                e = bs_q.pop_front();
                if (e >= 0) check("bit_len_tq", tq_cnt, e);
            end
            tq_cnt = 0;
        end
        if (sample_o) begin
            if (samp_cnt_q.size() == 0) begin
                check("unexpected_sample", 32'd1, 32'd0);
            end else begin
                check("sample_point_tq", tq_cnt, samp_cnt_q.pop_front());
                check("sample_bit", sample_bit_o, samp_bit_q.pop_front());
            end
        end
    endtask

    task automatic run_to(input int n);
        int k;
        k = 0;
        while (tq_cnt != n && k < 300) begin
            step();
            k++;
        end
        if (tq_cnt != n) check("run_to_timeout", tq_cnt, n);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((bs_q.size() != 0 || samp_cnt_q.size() != 0) && k < 400) begin
            step();
            k++;
        end
        check("pending_events", bs_q.size() + samp_cnt_q.size(), 0);
    endtask

    task automatic push_samp(input int c, input int b);
        samp_cnt_q.push_back(c);
        samp_bit_q.push_back(b);
    endtask

    // One falling edge on RX at the next (pulse-free) edge, then back to recessive.
    task automatic fall_pulse();
        rx_i = 1'b0;
        step();
        step();
        rx_i = 1'b1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic bs,
                              input logic cen, input logic smp, input logic sbit);
        check({tag, "_state"}, state_o, st);
        check({tag, "_bit_start"}, bit_start_o, bs);
        check({tag, "_clk_gen_en"}, clk_gen_en_o, cen);
        check({tag, "_sample"}, sample_o, smp);
        check({tag, "_sample_bit"}, sample_bit_o, sbit);
    endtask

    initial begin
        // Reset held (en_i and rx_i wiggling must not matter), release, first tq.
        tbl[0] = '{rst: 1'b0, en: 1'b0, rx: 1'b1, st: 2'd0, bs: 1'b0, cen: 1'b0, smp: 1'b0, sbit: 1'b1};
        tbl[1] = '{rst: 1'b0, en: 1'b1, rx: 1'b0, st: 2'd0, bs: 1'b0, cen: 1'b0, smp: 1'b0, sbit: 1'b1};
        tbl[2] = '{rst: 1'b1, en: 1'b1, rx: 1'b1, st: 2'd1, bs: 1'b1, cen: 1'b1, smp: 1'b0, sbit: 1'b1};
        tbl[3] = '{rst: 1'b1, en: 1'b1, rx: 1'b1, st: 2'd2, bs: 1'b0, cen: 1'b1, smp: 1'b0, sbit: 1'b1};

        bs_q.push_back(-1);
        for (int i = 0; i < 4; i++) begin
            reset_i = tbl[i].rst;
            en_i    = tbl[i].en;
            rx_i    = tbl[i].rx;
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].bs, tbl[i].cen,
                       tbl[i].smp, tbl[i].sbit);
        end

        // Nominal bits with RX recessive: 16 tq per bit, sample at 14 tq.
        push_samp(14, 1); bs_q.push_back(16);
        push_samp(14, 1); bs_q.push_back(16);
        drain();

        // Resync in TSEG1 (cnt=5) lengthens the bit to 17 tq; a second edge is ignored.
        push_samp(15, 1); bs_q.push_back(17);
        run_to(6);
        fall_pulse();
        run_to(9);
        fall_pulse();
        drain();

        // Resync at TSEG2 cnt=0 shortens phase2: 15 tq bit.
        push_samp(14, 1); bs_q.push_back(15);
        run_to(14);
        fall_pulse();
        drain();

        // Resync at TSEG2 cnt=1: bit ends on the very next cycle.
        push_samp(14, 1); bs_q.push_back(15);
        run_to(15);
        rx_i = 1'b0;
        step();
        check("early_end_state", state_o, 2'd1);
        check("early_end_bit_start", bit_start_o, 1'b1);
        step();
        rx_i = 1'b1;
        drain();

        // Hard sync coincident with a quantum pulse in TSEG2.
        push_samp(14, 1); bs_q.push_back(15);
        push_samp(13, 1); bs_q.push_back(15);
        run_to(14);
        while (phase != 3) step();
        hard_sync_i = 1'b1;
        rx_i = 1'b0;
        step();
        check("hard_sync_state", state_o, 2'd2);
        check("hard_sync_bit_start", bit_start_o, 1'b1);
        step();
        rx_i = 1'b1;
        hard_sync_i = 1'b0;
        drain();

        // Disable mid-TSEG1, then re-enable.
        run_to(5);
        en_i = 1'b0;
        step();
        check_outs("disable", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en_i = 1'b1;
        bs_q.push_back(-1);
        step();
        check_outs("reenable", 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);

        // Dominant sample (after a late TSEG1 resync), then reset mid-TSEG2.
        push_samp(15, 0);
        run_to(13);
        rx_i = 1'b0;
        run_to(15);
        step();
        check("pre_reset_state", state_o, 2'd3);
        reset_i = 1'b0;
        step();
        check_outs("mid_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("queues_empty", bs_q.size() + samp_cnt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
